// File: rtl/chunk_adder.sv
// Multi-cycle add/subtract unit: WIDTH-bit operands processed CHUNK bits per clock,
// with a registered inter-slice carry and valid/ready handshakes on both sides.
module chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic [CHUNK-1:0] a_slice, b_slice, s_slice;
  logic             c_slice;
  logic             accept, last;

  // Handshake outputs decode registered state only.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign last      = (idx == LAST_IDX);

  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx == IDXW'(i)) begin
        a_slice = opa[i*CHUNK +: CHUNK];
        b_slice = opb[i*CHUNK +: CHUNK];
      end
    end
    {c_slice, s_slice} = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)    state_nxt = BUSY;
      BUSY:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Subtract is folded into the operands at accept: a + ~b + ~cin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      opa   <= a;
      opb   <= b ^ {WIDTH{sub}};
      carry <= cin ^ sub;
      idx   <= '0;
    end else if (state == BUSY) begin
      for (int unsigned i = 0; i < NCHUNK; i++) begin
        if (idx == IDXW'(i)) sum[i*CHUNK +: CHUNK] <= s_slice;
      end
      carry <= c_slice;
      idx   <= idx + IDXW'(1);
      if (last) cout <= c_slice;
    end
  end

endmodule

// File: tb/tb_chunk_adder.sv
// Directed bench for chunk_adder: default 8/2 instance plus 16/16 and 16/1 sweeps.
module tb_chunk_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Index 0: WIDTH=8 CHUNK=2, 1: WIDTH=16 CHUNK=16, 2: WIDTH=16 CHUNK=1
  logic        in_valid_s [3];
  logic        out_ready_s[3];
  logic        cin_s      [3];
  logic        sub_s      [3];
  logic [15:0] a_s        [3];
  logic [15:0] b_s        [3];
  logic        in_ready_s [3];
  logic        out_valid_s[3];
  logic [15:0] sum_s      [3];
  logic        cout_s     [3];

  logic       ir0, ir1, ir2, ov0, ov1, ov2, co0, co1, co2;
  logic [7:0]  sum0;
  logic [15:0] sum1, sum2;

  assign in_ready_s[0]  = ir0;  assign in_ready_s[1]  = ir1;  assign in_ready_s[2]  = ir2;
  assign out_valid_s[0] = ov0;  assign out_valid_s[1] = ov1;  assign out_valid_s[2] = ov2;
  assign cout_s[0]      = co0;  assign cout_s[1]      = co1;  assign cout_s[2]      = co2;
  assign sum_s[0] = {8'h00, sum0};
  assign sum_s[1] = sum1;
  assign sum_s[2] = sum2;

  chunk_adder #(.WIDTH(8), .CHUNK(2)) u_w8c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(ir0),
    .a(a_s[0][7:0]), .b(b_s[0][7:0]), .cin(cin_s[0]), .sub(sub_s[0]),
    .out_valid(ov0), .out_ready(out_ready_s[0]), .sum(sum0), .cout(co0));

  chunk_adder #(.WIDTH(16), .CHUNK(16)) u_w16c16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(ir1),
    .a(a_s[1]), .b(b_s[1]), .cin(cin_s[1]), .sub(sub_s[1]),
    .out_valid(ov1), .out_ready(out_ready_s[1]), .sum(sum1), .cout(co1));

  chunk_adder #(.WIDTH(16), .CHUNK(1)) u_w16c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_s[2]), .in_ready(ir2),
    .a(a_s[2]), .b(b_s[2]), .cin(cin_s[2]), .sub(sub_s[2]),
    .out_valid(ov2), .out_ready(out_ready_s[2]), .sum(sum2), .cout(co2));

  int errors = 0;
  int checks = 0;

  // Drives one operation on instance u, measures cycles from accept to out_valid,
  // captures the result, then completes the output handshake.
  task automatic do_op(input int u, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic sb,
                       output int lat, output logic [15:0] s, output logic co);
    @(negedge clk);
    a_s[u] = a; b_s[u] = b; cin_s[u] = ci; sub_s[u] = sb; in_valid_s[u] = 1'b1;
    @(negedge clk);
    in_valid_s[u] = 1'b0;
    lat = 0;
    while (!out_valid_s[u] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    s  = sum_s[u];
    co = cout_s[u];
    out_ready_s[u] = 1'b1;
    @(negedge clk);
    out_ready_s[u] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (sum_s[u] !== 16'h0000 || cout_s[u] !== 1'b0 || out_valid_s[u] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state[%0d]: sum=%h cout=%b out_valid=%b, want 0/0/0",
                 u, sum_s[u], cout_s[u], out_valid_s[u]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (in_ready_s[u] !== 1'b1) begin
        errors++;
        $display("FAIL reset_in_ready[%0d]: got %b want 1", u, in_ready_s[u]);
      end
    end
  endtask

  task automatic test_add();
    int lat; logic [15:0] s; logic co;
    do_op(0, 16'h5A, 16'h3C, 1'b0, 1'b0, lat, s, co);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d want 4", lat); end
    checks++;
    if (s[7:0] !== 8'h96 || co !== 1'b0) begin
      errors++; $display("FAIL add_5A_3C: got sum=%h cout=%b want 96/0", s[7:0], co);
    end
    checks++;
    if (in_ready_s[0] !== 1'b1 || out_valid_s[0] !== 1'b0) begin
      errors++; $display("FAIL add_return_idle: in_ready=%b out_valid=%b want 1/0",
                         in_ready_s[0], out_valid_s[0]);
    end
  endtask

  task automatic test_wrap();
    int lat; logic [15:0] s; logic co;
    do_op(0, 16'hFF, 16'h01, 1'b0, 1'b0, lat, s, co);
    checks++;
    if (s[7:0] !== 8'h00 || co !== 1'b1) begin
      errors++; $display("FAIL wrap_FF_01: got sum=%h cout=%b want 00/1", s[7:0], co);
    end
    do_op(0, 16'hFF, 16'hFF, 1'b1, 1'b0, lat, s, co);
    checks++;
    if (s[7:0] !== 8'hFF || co !== 1'b1) begin
      errors++; $display("FAIL wrap_FF_FF_c1: got sum=%h cout=%b want FF/1", s[7:0], co);
    end
  endtask

  task automatic test_subtract();
    int lat; logic [15:0] s; logic co;
    do_op(0, 16'h10, 16'h01, 1'b0, 1'b1, lat, s, co);
    checks++;
    if (s[7:0] !== 8'h0F || co !== 1'b1) begin
      errors++; $display("FAIL sub_10_01: got sum=%h cout=%b want 0F/1", s[7:0], co);
    end
    do_op(0, 16'h00, 16'h01, 1'b0, 1'b1, lat, s, co);
    checks++;
    if (s[7:0] !== 8'hFF || co !== 1'b0) begin
      errors++; $display("FAIL sub_00_01: got sum=%h cout=%b want FF/0", s[7:0], co);
    end
    do_op(0, 16'h05, 16'h02, 1'b1, 1'b1, lat, s, co);
    checks++;
    if (s[7:0] !== 8'h02 || co !== 1'b1) begin
      errors++; $display("FAIL sub_05_02_b1: got sum=%h cout=%b want 02/1", s[7:0], co);
    end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL sub_latency: got %0d want 4", lat); end
  endtask

  task automatic test_backpressure();
    int lat;
    // 0x12 + 0x34 = 0x46, no carry out
    @(negedge clk);
    a_s[0] = 16'h12; b_s[0] = 16'h34; cin_s[0] = 1'b0; sub_s[0] = 1'b0; in_valid_s[0] = 1'b1;
    @(negedge clk);
    in_valid_s[0] = 1'b0;
    lat = 0;
    while (!out_valid_s[0] && lat < 100) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL bp_latency: got %0d want 4", lat); end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a_s[0] = 16'hAA; b_s[0] = 16'h55; cin_s[0] = 1'b1; in_valid_s[0] = 1'b1;
      end else begin
        in_valid_s[0] = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (sum_s[0] !== 16'h0046 || cout_s[0] !== 1'b0 || in_ready_s[0] !== 1'b0 ||
          out_valid_s[0] !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: sum=%h cout=%b in_ready=%b out_valid=%b want 46/0/0/1",
                 i, sum_s[0][7:0], cout_s[0], in_ready_s[0], out_valid_s[0]);
      end
    end
    in_valid_s[0] = 1'b0;
    out_ready_s[0] = 1'b1;
    @(negedge clk);
    out_ready_s[0] = 1'b0;
    checks++;
    if (in_ready_s[0] !== 1'b1 || out_valid_s[0] !== 1'b0 || sum_s[0] !== 16'h0046) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b sum=%h want 1/0/46",
               in_ready_s[0], out_valid_s[0], sum_s[0][7:0]);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [15:0] s; logic co;
    @(negedge clk);
    a_s[0] = 16'hF0; b_s[0] = 16'h0F; cin_s[0] = 1'b1; sub_s[0] = 1'b0; in_valid_s[0] = 1'b1;
    @(negedge clk);
    in_valid_s[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid_s[0] !== 1'b0 || sum_s[0] !== 16'h0000 || cout_s[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: out_valid=%b sum=%h cout=%b want 0/00/0",
               out_valid_s[0], sum_s[0][7:0], cout_s[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready_s[0] !== 1'b1 || out_valid_s[0] !== 1'b0) begin
      errors++; $display("FAIL rst_mid_idle: in_ready=%b out_valid=%b want 1/0",
                         in_ready_s[0], out_valid_s[0]);
    end
    do_op(0, 16'h01, 16'h01, 1'b0, 1'b0, lat, s, co);
    checks++;
    if (s[7:0] !== 8'h02 || co !== 1'b0 || lat !== 4) begin
      errors++; $display("FAIL rst_mid_fresh: sum=%h cout=%b lat=%0d want 02/0/4", s[7:0], co, lat);
    end
  endtask

  task automatic test_param_sweep();
    int lat; logic [15:0] s; logic co;
    do_op(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, s, co);
    checks++;
    if (s !== 16'h0000 || co !== 1'b1) begin
      errors++; $display("FAIL w16c16_result: sum=%h cout=%b want 0000/1", s, co);
    end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL w16c16_latency: got %0d want 1", lat); end
    do_op(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, s, co);
    checks++;
    if (s !== 16'h0000 || co !== 1'b1) begin
      errors++; $display("FAIL w16c1_result: sum=%h cout=%b want 0000/1", s, co);
    end
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL w16c1_latency: got %0d want 16", lat); end
    do_op(2, 16'h1234, 16'h0235, 1'b1, 1'b1, lat, s, co);
    checks++;
    if (s !== 16'h0FFE || co !== 1'b1) begin
      errors++; $display("FAIL w16c1_sub: sum=%h cout=%b want 0FFE/1", s, co);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      in_valid_s[u] = 1'b0; out_ready_s[u] = 1'b0;
      cin_s[u] = 1'b0; sub_s[u] = 1'b0; a_s[u] = '0; b_s[u] = '0;
    end
    test_reset();
    test_add();
    test_wrap();
    test_subtract();
    test_backpressure();
    test_reset_mid_op();
    test_param_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
